// File: rtl/quad_pkg.sv
// Shared types and widths for the quadruple-counter front end.
// Latency: none (declarations only). Backpressure: not applicable.
// Both the loader and the integrating top import this package.
package quad_pkg;

    localparam int COUNT_W = 16;
    localparam int K_W     = 8;
    localparam int N_DEF   = 100;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/quad_frame_loader.sv
// Packs streamed elements into an N-element frame for the quadruple counter, then captures its count.
// Latency: result valid SETTLE_CYC+1 cycles after the terminating element is accepted.
// Backpressure: s_ready low from frame end until the result handshakes; one frame in flight.
module quad_frame_loader
    import quad_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int ELEM_W     = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ELEM_W-1:0]     s_data,
    input  logic                  s_last,
    input  logic [K_W-1:0]        s_k,
    output logic [N*ELEM_W-1:0]   arr_out,
    output logic [K_W-1:0]        k_out,
    input  logic [COUNT_W-1:0]    cnt_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [COUNT_W-1:0]    m_count,
    output logic                  m_short,
    output logic                  m_long
);

    localparam int FILL_W = $clog2(N + 1);
    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [FILL_W-1:0] LAST_IDX = FILL_W'(N - 1);
    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);

    state_t              state;
    state_t              state_nxt;
    logic [FILL_W-1:0]   fill_cnt;
    logic [FILL_W-1:0]   wr_idx;
    logic [SET_W-1:0]    set_cnt;
    logic                short_flag;
    logic                long_flag;
    logic                accept;
    logic                storing;
    logic                at_last_idx;
    logic                settle_done;
    logic                result_taken;

    assign accept       = s_valid && s_ready;
    // The first element always lands at index 0, whatever the fill counter holds.
    assign wr_idx       = (state == IDLE) ? '0 : fill_cnt;
    assign storing      = accept && ((state == IDLE) || (state == FILL));
    assign at_last_idx  = (wr_idx == LAST_IDX);
    assign settle_done  = (state == SETTLE) && (set_cnt == SET_LAST);
    assign result_taken = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, FILL: begin
                if (accept) begin
                    if (at_last_idx) begin
                        state_nxt = s_last ? SETTLE : DRAIN;
                    end else if (s_last) begin
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (result_taken) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs come from registered state only; rst masks s_ready.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state)
            IDLE, FILL, DRAIN: s_ready = !rst;
            HOLD:              m_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arr_out    <= '0;
            k_out      <= '0;
            fill_cnt   <= '0;
            set_cnt    <= '0;
            short_flag <= 1'b0;
            long_flag  <= 1'b0;
            m_count    <= '0;
            m_short    <= 1'b0;
            m_long     <= 1'b0;
        end else begin
            if (storing) begin
                arr_out[wr_idx*ELEM_W +: ELEM_W] <= s_data;
                fill_cnt <= wr_idx + 1'b1;
                if (at_last_idx && !s_last) begin
                    long_flag <= 1'b1;
                end
                if (!at_last_idx && s_last) begin
                    short_flag <= 1'b1;
                end
            end

            if (accept && (state == IDLE)) begin
                k_out <= s_k;
            end

            if (state == SETTLE) begin
                set_cnt <= settle_done ? '0 : set_cnt + 1'b1;
            end

            if (settle_done) begin
                m_count <= cnt_in;
                m_short <= short_flag;
                m_long  <= long_flag;
            end

            // Clearing here leaves the next frame zero-filled; k_out and results persist.
            if ((state == HOLD) && result_taken) begin
                arr_out    <= '0;
                fill_cnt   <= '0;
                short_flag <= 1'b0;
                long_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_frame_loader.sv
// Bench for quad_frame_loader: frame-level model with a per-cycle compare process.
module tb_quad_frame_loader;
    import quad_pkg::*;

    localparam int N      = 100;
    localparam int SETTLE = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                s_valid;
    logic                s_ready;
    logic                s_data;
    logic                s_last;
    logic [7:0]          s_k;
    logic [N-1:0]        arr_out;
    logic [7:0]          k_out;
    logic [15:0]         cnt_in;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic [15:0]         m_count;
    logic                m_short;
    logic                m_long;

    quad_frame_loader #(.N(N), .ELEM_W(1), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_k(s_k),
        .arr_out(arr_out), .k_out(k_out), .cnt_in(cnt_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count),
        .m_short(m_short), .m_long(m_long)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit stub_const = 1'b1;
    bit mr_hold = 1'b0;
    int mr_rand_pct = 0;

    typedef struct {
        int           t_last;
        logic [N-1:0] arr;
        logic [7:0]   k;
        logic [15:0]  cnt;
        bit           shrt;
        bit           lng;
    } exp_t;

    exp_t q[$];
    logic ev [0:255];
    logic [N-1:0] ones = '1;

    // Counter stub: position-weighted sum of set bits mixed with k.
    function automatic logic [15:0] cnt_fn(input logic [N-1:0] a, input logic [7:0] k);
        int s = 0;
        for (int i = 0; i < N; i++) if (a[i]) s += i + 1;
        return 16'(k * 257) ^ 16'(s);
    endfunction

    assign cnt_in = stub_const ? 16'h1234 : cnt_fn(arr_out, k_out);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = mr_hold ? 1'b0 : ($urandom_range(99) >= mr_rand_pct);
    end

    bit hv, exp_mv, exp_sr;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            hv     = q.size() > 0;
            exp_mv = hv && (cyc >= q[0].t_last + 1 + SETTLE);
            exp_sr = !(hv && (cyc > q[0].t_last));
            chk("m_valid", 128'(m_valid), 128'(exp_mv));
            chk("s_ready", 128'(s_ready), 128'(exp_sr));
            if (hv && (cyc > q[0].t_last)) begin
                chk("arr_out", 128'(arr_out), 128'(q[0].arr));
                chk("k_out", 128'(k_out), 128'(q[0].k));
            end
            if (exp_mv && m_valid) begin
                chk("m_count", 128'(m_count), 128'(q[0].cnt));
                chk("m_short", 128'(m_short), 128'(q[0].shrt));
                chk("m_long", 128'(m_long), 128'(q[0].lng));
                if (m_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send_frame(input int n, input logic [7:0] k, input int gap_pct, input bit no_last);
        exp_t e;
        int i = 0;
        e.arr = '0;
        e.k = k;
        for (int j = 0; j < n && j < N; j++) e.arr[j] = ev[j];
        e.cnt = stub_const ? 16'h1234 : cnt_fn(e.arr, k);
        e.shrt = (n < N);
        e.lng = (n > N);
        e.t_last = 0;
        while (i < n) begin
            if ($urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = 1'($urandom);
                s_last  = 1'($urandom);
                s_k     = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = ev[i];
                s_last  = !no_last && (i == n - 1);
                s_k     = (i == 0) ? k : 8'($urandom);
                if (!no_last && i == n - 1) begin
                    e.t_last = cyc;
                    q.push_back(e);
                end
                i++;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_mvalid(input string name);
        int b = 0;
        while (!m_valid && b < 400) begin
            @(negedge clk);
            b++;
        end
        chk(name, 128'(m_valid), 128'(1));
    endtask

    task automatic wait_done(input string name);
        int b = 0;
        while (b < 400) begin
            @(posedge clk); #1;
            b++;
            if (q.size() == 0) break;
            s_valid = 1'($urandom);
            s_data  = 1'($urandom);
            s_last  = 1'($urandom);
            s_k     = 8'($urandom);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: pending results %0d expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tl;
        int n;
        int gap;
        logic [7:0] k;

        rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0; s_k = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset s_ready", 128'(s_ready), 128'(0));
        chk("reset m_valid", 128'(m_valid), 128'(0));
        chk("reset arr_out", 128'(arr_out), 128'(0));
        chk("reset k_out", 128'(k_out), 128'(0));
        chk("reset m_count", 128'(m_count), 128'(0));
        chk("reset flags", 128'({m_short, m_long}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Full frame of ones against the constant stub
        for (int i = 0; i < 256; i++) ev[i] = 1'b1;
        send_frame(100, 8'd4, 0, 1'b0);
        tl = q[0].t_last;
        wait_mvalid("full valid seen");
        chk("full latency", 128'(cyc - tl), 128'(3));
        chk("full m_count", 128'(m_count), 128'(16'h1234));
        chk("full m_short", 128'(m_short), 128'(0));
        chk("full m_long", 128'(m_long), 128'(0));
        chk("full arr_out", 128'(arr_out), 128'(ones));
        chk("full k_out", 128'(k_out), 128'(4));
        wait_done("full");

        // Short frame 1,0,1: weight sum 1+3=4, 7*257=0x707, xor -> 0x703
        stub_const = 1'b0;
        ev[0] = 1'b1; ev[1] = 1'b0; ev[2] = 1'b1;
        send_frame(3, 8'd7, 0, 1'b0);
        wait_mvalid("short valid seen");
        chk("short arr_out", 128'(arr_out), 128'(5));
        chk("short m_short", 128'(m_short), 128'(1));
        chk("short m_long", 128'(m_long), 128'(0));
        chk("short m_count", 128'(m_count), 128'(16'h0703));
        wait_done("short");

        // Long frame: 100 ones then 3 zeros; 5050 ^ 0x404 = 0x17BE
        for (int i = 0; i < 100; i++) ev[i] = 1'b1;
        for (int i = 100; i < 103; i++) ev[i] = 1'b0;
        send_frame(103, 8'd4, 0, 1'b0);
        tl = q[0].t_last;
        wait_mvalid("long valid seen");
        chk("long latency", 128'(cyc - tl), 128'(3));
        chk("long m_long", 128'(m_long), 128'(1));
        chk("long m_short", 128'(m_short), 128'(0));
        chk("long arr_out", 128'(arr_out), 128'(ones));
        chk("long m_count", 128'(m_count), 128'(16'h17BE));
        wait_done("long");

        // Backpressure: result held for 10 cycles, then a one-element frame right behind it
        for (int i = 0; i < 256; i++) ev[i] = 1'($urandom);
        mr_hold = 1'b1;
        send_frame(100, 8'h3C, 0, 1'b0);
        wait_mvalid("bp valid seen");
        repeat (10) begin
            @(negedge clk);
            chk("bp m_valid held", 128'(m_valid), 128'(1));
            chk("bp s_ready low", 128'(s_ready), 128'(0));
        end
        mr_hold = 1'b0;
        wait_done("bp");
        ev[0] = 1'b1;
        send_frame(1, 8'hA5, 0, 1'b0);
        chk("bp next k_out", 128'(k_out), 128'(8'hA5));
        wait_done("bp next");

        // Reset after 50 elements of an unterminated frame
        for (int i = 0; i < 256; i++) ev[i] = 1'($urandom);
        send_frame(50, 8'h11, 0, 1'b1);
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        chk("midrst arr_out", 128'(arr_out), 128'(0));
        chk("midrst k_out", 128'(k_out), 128'(0));
        chk("midrst m_count", 128'(m_count), 128'(0));
        chk("midrst m_valid", 128'(m_valid), 128'(0));
        chk("midrst flags", 128'({m_short, m_long}), 128'(0));
        chk("midrst s_ready", 128'(s_ready), 128'(0));
        rst = 1'b0;
        q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 256; i++) ev[i] = 1'($urandom);
        send_frame(100, 8'h5A, 0, 1'b0);
        wait_done("after reset");

        // Random frames; odd passes replay the previous frame with input gaps
        mr_rand_pct = 50;
        n = 100;
        k = 8'h00;
        for (int f = 0; f < 24; f++) begin
            if (f % 2 == 0) begin
                case ($urandom_range(2))
                    0:       n = $urandom_range(1, 99);
                    1:       n = 100;
                    default: n = $urandom_range(101, 110);
                endcase
                k = 8'($urandom);
                for (int i = 0; i < 256; i++) ev[i] = 1'($urandom);
                gap = 0;
            end else begin
                gap = $urandom_range(20, 50);
            end
            send_frame(n, k, gap, 1'b0);
            wait_done("random");
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_frame_loader.md
# quad_frame_loader

Sequential front end for `QuadruplesCounter`: accepts array elements one per handshake, packs them into the `N`-element frame the counter consumes, and presents the frame with its target `k`. It waits a fixed settle interval for the combinational counter to resolve, then captures the count and offers it downstream on a valid/ready result port. One frame is in flight at a time.

## Interface
- `N`, 100, elements per frame.
- `ELEM_W`, 1, bits per element.
- `SETTLE_CYC`, 2, cycles the frame is held before `cnt_in` is sampled; legal range is 1 or more.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_valid`  in  1  element valid.
- `s_ready`  out  1  element ready.
- `s_data`  in  ELEM_W  element value.
- `s_last`  in  1  final element of frame.
- `s_k`  in  8  target sum; sampled with the first element of a frame.
- `arr_out`  out  N*ELEM_W  packed frame to counter `input_array`.
- `k_out`  out  8  to counter `k`.
- `cnt_in`  in  16  from counter `count`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result ready.
- `m_count`  out  16  captured count.
- `m_short`  out  1  frame ended (`s_last`) before N elements.
- `m_long`  out  1  more than N elements were offered before `s_last`.

## Operation
- **States**
  - IDLE: `s_ready`=1; wait for first element.
  - FILL: `s_ready`=1; collecting elements.
  - DRAIN: `s_ready`=1; discarding surplus elements.
  - SETTLE: `s_ready`=0; waiting `SETTLE_CYC` cycles.
  - HOLD: `s_ready`=0; `m_valid`=1.
- **Accept rule:** an element is accepted when `s_valid && s_ready`.
- **Element placement:** element index `i` (0-based arrival order) is written to `arr_out[i*ELEM_W +: ELEM_W]`. The fill counter is `$clog2(N+1)` bits.
- **IDLE:** on accept, store the element at index 0 and latch `s_k` into `k_out`.
  - With `s_last`: go to SETTLE and set the short flag.
  - Otherwise: go to FILL.
  - `N`=1 follows the same rule as reaching index N-1 in FILL.
- **FILL:** on accept, store at the current index.
  - Index N-1 with `s_last`: go to SETTLE.
  - Index N-1 without `s_last`: set the long flag and go to DRAIN.
  - Index below N-1 with `s_last`: set the short flag and go to SETTLE.
- **Zero fill:** unfilled positions stay 0, so a short frame is zero-filled.
- **DRAIN:** accept and discard elements; on an accepted `s_last`, go to SETTLE.
- **SETTLE:** `arr_out` and `k_out` are held stable. The settle counter runs 0..`SETTLE_CYC`-1. On its last count:
  - register `m_count` <= `cnt_in`;
  - update `m_short` and `m_long` from their flags;
  - go to HOLD.
- **HOLD:** outputs held. On `m_valid && m_ready`:
  - clear `arr_out`, the fill counter and both flags;
  - go to IDLE.
  - `m_count`, `m_short` and `m_long` keep their last values until the next capture.
- `k_out` holds its value until the next frame's first accept.

## Timing
- **Reset values:** state IDLE; `arr_out`=0, `k_out`=0, `m_count`=0, `m_valid`=0, `m_short`=0, `m_long`=0, all counters 0. `s_ready` is 0 while `rst` is high.
- **Output decode:** `s_ready` and `m_valid` are decoded from registered state; there is no combinational path from `s_valid` or `m_ready`.
- **Latency:** if the terminating element is accepted in cycle t, then:
  - `m_valid` is high from cycle t+1+`SETTLE_CYC`;
  - `cnt_in` is sampled at the edge ending cycle t+`SETTLE_CYC`.
- **Back-to-back frames:** the handshake in cycle h puts IDLE in h+1, so the first element of the next frame can be accepted in h+1.
- **Throughput:** minimum frame period is N+`SETTLE_CYC`+1 cycles with `m_ready` tied high.
- **Reset mid-frame:** `rst` in any state discards the partial frame and pending result; all outputs return to their reset values on the next edge.
- **Input stalls:** `s_valid` gaps in FILL or DRAIN do not advance any counter. `s_data` and `s_last` are ignored when not accepted.

## Structure
- **Shared package `quad_pkg`:**
  - state enum `{IDLE, FILL, DRAIN, SETTLE, HOLD}`;
  - `COUNT_W`=16, `K_W`=8;
  - default `N`=100.
- **Sub-module:** none is required. A separate `QuadruplesCounter` instance is wired outside by the integrating top `quad_count_top`.

## Test plan
- **Full frame:** 100 elements, all 1, `s_k`=4, counter stub returning 0x1234 → `m_valid` at t+3; `m_count`=0x1234, `m_short`=0, `m_long`=0; `arr_out` all ones.
- **Short frame:** 3 elements (1,0,1) with `s_last` on the third → `arr_out`=...0101 with bits 99..3 = 0; `m_short`=1.
- **Long frame:** 103 elements with `s_last` on #103 → elements 101..103 are consumed (`s_ready`=1) and do not alter `arr_out`; `m_long`=1; `m_valid` 3 cycles after the `s_last` accept.
- **Backpressure:** `m_ready` low for 10 cycles in HOLD → `m_valid`, `m_count` and `arr_out` are stable and `s_ready`=0; after the handshake, the next frame's first element is accepted the following cycle with a new `k_out`.
- **Reset mid-frame:** `rst` after 50 elements → next cycle all outputs are 0 and state is IDLE; a subsequent full frame completes correctly.
- **Stalls:** random `s_valid` gaps within a frame → identical `arr_out` and `m_count` to the gap-free run.
